// File: rtl/alu_cmd_sequencer.sv
// ============================================================================
// Module   : alu_cmd_sequencer
// Brief    : Queues (op, operand) commands, drives the calculator datapath,
//            captures result/error after a fixed settle time and returns it
//            on a valid/ready response port; error-free results update acc.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_cmd_sequencer #(
   parameter int         DEPTH  = 4,
   parameter int         SETTLE = 2,
   parameter logic [3:0] CLR_OP = 4'd13
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_op,
   input  logic [15:0] cmd_operand,
   output logic [15:0] alu_input1,
   output logic [15:0] alu_input2,
   output logic [3:0]  alu_op_code,
   input  logic [31:0] alu_output1,
   input  logic [1:0]  alu_err_code,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic [1:0]  res_err,
   output logic [31:0] acc,
   output logic        err_sticky,
   output logic        busy
);

   localparam int             c_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int             c_CW   = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
   localparam logic [c_AW:0]  c_FULL = (c_AW + 1)'(DEPTH);
   localparam logic [c_CW-1:0] c_LAST = c_CW'(SETTLE - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_pop;
   logic              w_capture;
   logic              w_resp_done;

   logic [19:0]       r_mem [DEPTH];
   logic [c_AW-1:0]   r_wr_ptr;
   logic [c_AW-1:0]   r_rd_ptr;
   logic [c_AW:0]     r_count;
   logic [c_CW-1:0]   r_cnt;

   logic [15:0]       r_input1;
   logic [3:0]        r_op_code;
   logic [31:0]       r_res_data;
   logic [1:0]        r_res_err;
   logic              r_res_valid;
   logic [31:0]       r_acc;
   logic              r_err_sticky;

   logic              w_full;
   logic              w_not_empty;
   logic              w_push;
   logic [19:0]       w_head;

   assign w_full      = (r_count == c_FULL);
   assign w_not_empty = (r_count != '0);
   assign w_push      = cmd_valid && !w_full;
   assign w_head      = r_mem[r_rd_ptr];

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_capture   = 1'b0;
      w_resp_done = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_not_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (r_cnt == c_LAST) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            // res_valid is always high here, so res_ready alone is the handshake
            if (res_ready) begin
               w_resp_done = 1'b1;
               if (w_not_empty) begin
                  w_pop       = 1'b1;
                  w_state_nxt = ST_SETTLE;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- FIFO
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {cmd_op, cmd_operand};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (c_AW + 1)'(1);
            2'b01:   r_count <= r_count - (c_AW + 1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt        <= '0;
         r_input1     <= '0;
         r_op_code    <= '0;
         r_res_data   <= '0;
         r_res_err    <= '0;
         r_res_valid  <= 1'b0;
         r_acc        <= '0;
         r_err_sticky <= 1'b0;
      end else begin
         if (w_pop) begin
            r_cnt     <= '0;
            r_input1  <= w_head[15:0];
            r_op_code <= w_head[19:16];
         end else if (r_state == ST_SETTLE) begin
            r_cnt <= r_cnt + c_CW'(1);
         end

         if (w_capture) begin
            r_res_data  <= alu_output1;
            r_res_err   <= alu_err_code;
            r_res_valid <= 1'b1;
            if (alu_err_code == 2'b00) begin
               r_acc <= alu_output1;
               if (r_op_code == CLR_OP) begin
                  r_err_sticky <= 1'b0;
               end
            end else begin
               r_err_sticky <= 1'b1;
            end
         end else if (w_resp_done) begin
            r_res_valid <= 1'b0;
         end
      end
   end

   assign cmd_ready   = !w_full;
   assign alu_input1  = r_input1;
   assign alu_input2  = r_acc[15:0];
   assign alu_op_code = r_op_code;
   assign res_valid   = r_res_valid;
   assign res_data    = r_res_data;
   assign res_err     = r_res_err;
   assign acc         = r_acc;
   assign err_sticky  = r_err_sticky;
   assign busy        = (r_state != ST_IDLE) || w_not_empty;

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
// ============================================================================
// Module   : tb_alu_cmd_sequencer
// Brief    : Self-checking bench: directed plan plus random traffic against a
//            sequential command-by-command reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_cmd_sequencer;

   localparam int         c_SETTLE = 2;
   localparam logic [3:0] c_CLR    = 4'd13;

   typedef struct {
      logic [3:0]  op;
      logic [15:0] opnd;
   } cmd_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [3:0]  cmd_op = '0;
   logic [15:0] cmd_operand = '0;
   logic [15:0] alu_input1;
   logic [15:0] alu_input2;
   logic [3:0]  alu_op_code;
   logic [31:0] alu_output1;
   logic [1:0]  alu_err_code;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [31:0] res_data;
   logic [1:0]  res_err;
   logic [31:0] acc;
   logic        err_sticky;
   logic        busy;

   int n_checks = 0;
   int n_pass   = 0;

   cmd_t        cmd_q[$];
   logic [31:0] m_acc    = '0;
   logic        m_sticky = 1'b0;

   alu_cmd_sequencer #(.DEPTH(4), .SETTLE(c_SETTLE), .CLR_OP(c_CLR)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_operand(cmd_operand),
      .alu_input1(alu_input1), .alu_input2(alu_input2), .alu_op_code(alu_op_code),
      .alu_output1(alu_output1), .alu_err_code(alu_err_code),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_err(res_err),
      .acc(acc), .err_sticky(err_sticky), .busy(busy)
   );

   always #5 clk = ~clk;

   // Calculator datapath stand-in: {output1, err_code}
   function automatic logic [33:0] calc(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
      logic [31:0] r;
      logic [1:0]  e;
      r = 32'd0;
      e = 2'b00;
      case (op)
         4'd0: begin r = {16'd0, a} + {16'd0, b}; e[0] = r[16]; end
         4'd1: begin r = {16'd0, a} - {16'd0, b}; e[0] = (a < b); end
         4'd2: r = {16'd0, a} * {16'd0, b};
         4'd3: if (b == 16'd0) e = 2'b10; else r = {16'd0, a / b};
         4'd4: if (b == 16'd0) e = 2'b10; else r = {16'd0, a % b};
         4'd13: r = 32'd0;
         default: r = {16'd0, a ^ b};
      endcase
      return {r, e};
   endfunction

   assign {alu_output1, alu_err_code} = calc(alu_op_code, alu_input1, alu_input2);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Result scoreboard: each handshaken result is the next queued command
   // applied to the model accumulator, strictly in push order.
   logic        stall_prev = 1'b0;
   logic [31:0] held_data;
   logic [1:0]  held_err;
   logic [31:0] held_acc;
   logic [15:0] held_in1;

   always @(negedge clk) begin
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("hold_data", res_data, held_data);
            check("hold_err", {30'd0, res_err}, {30'd0, held_err});
            check("hold_acc", acc, held_acc);
            check("hold_nopop", {16'd0, alu_input1}, {16'd0, held_in1});
         end
         stall_prev = res_valid && !res_ready;
         held_data  = res_data;
         held_err   = res_err;
         held_acc   = acc;
         held_in1   = alu_input1;

         if (res_valid && res_ready) begin
            if (cmd_q.size() == 0) begin
               check("unexpected_res", {31'd0, res_valid}, 32'd0);
            end else begin
               cmd_t        c;
               logic [33:0] x;
               c = cmd_q.pop_front();
               x = calc(c.op, c.opnd, m_acc[15:0]);
               if (x[1:0] == 2'b00) begin
                  m_acc = x[33:2];
                  if (c.op == c_CLR) m_sticky = 1'b0;
               end else begin
                  m_sticky = 1'b1;
               end
               check("res_data", res_data, x[33:2]);
               check("res_err", {30'd0, res_err}, {30'd0, x[1:0]});
               check("acc", acc, m_acc);
               check("err_sticky", {31'd0, err_sticky}, {31'd0, m_sticky});
            end
         end
         if (cmd_valid && cmd_ready) begin
            cmd_q.push_back('{op: cmd_op, opnd: cmd_operand});
         end
      end
   end

   task automatic push_cmd(input logic [3:0] op, input logic [15:0] opnd);
      logic ok;
      ok          = 1'b0;
      cmd_valid   = 1'b1;
      cmd_op      = op;
      cmd_operand = opnd;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("push_timeout", {31'd0, cmd_ready}, 32'd1);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input int max_cycles);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < max_cycles; i++) begin
         @(negedge clk);
         if (!busy && !res_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("idle_timeout", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
   endtask

   logic [3:0] ops [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd13, 4'd7};
   logic       rdone;

   initial begin
      // ---- reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", {31'd0, res_valid}, 32'd0);
      check("rst_acc", acc, 32'd0);
      check("rst_ready", {31'd0, cmd_ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_in1", {16'd0, alu_input1}, 32'd0);
      check("rst_data", res_data, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // ---- add with latency checks
      res_ready = 1'b1;
      push_cmd(4'd0, 16'd11);
      @(negedge clk);
      check("lat_t0_valid", {31'd0, res_valid}, 32'd0);
      @(negedge clk);
      check("lat_in1", {16'd0, alu_input1}, 32'd11);
      check("lat_in2", {16'd0, alu_input2}, 32'd0);
      check("lat_t1_valid", {31'd0, res_valid}, 32'd0);
      @(negedge clk);
      check("lat_t2_valid", {31'd0, res_valid}, 32'd0);
      @(negedge clk);
      check("lat_t3_valid", {31'd0, res_valid}, 32'd1);
      check("add_data", res_data, 32'd11);
      check("add_acc", acc, 32'd11);
      wait_idle(50);

      // ---- chained sub/mul, clear, divide by zero, clear sticky
      push_cmd(4'd1, 16'd15);
      wait_idle(50);
      check("sub_acc", acc, 32'd4);
      push_cmd(4'd2, 16'd3);
      wait_idle(50);
      check("mul_acc", acc, 32'd12);
      push_cmd(c_CLR, 16'd0);
      push_cmd(4'd3, 16'd11);
      wait_idle(50);
      check("div0_acc", acc, 32'd0);
      check("div0_err", {30'd0, res_err}, 32'd2);
      check("div0_sticky", {31'd0, err_sticky}, 32'd1);
      push_cmd(c_CLR, 16'd5);
      wait_idle(50);
      check("clr_sticky", {31'd0, err_sticky}, 32'd0);

      // ---- FIFO full with a stalled consumer
      res_ready = 1'b0;
      for (int i = 0; i < 5; i++) push_cmd(4'd0, 16'(100 + i));
      cmd_valid   = 1'b1;
      cmd_op      = 4'd0;
      cmd_operand = 16'd105;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("full_ready", {31'd0, cmd_ready}, 32'd0);
      end
      check("full_busy", {31'd0, busy}, 32'd1);
      @(posedge clk);
      #1;
      res_ready = 1'b1;
      push_cmd(4'd0, 16'd105);
      wait_idle(200);

      // ---- backpressure for 10 cycles, then same-edge pop
      res_ready = 1'b0;
      push_cmd(4'd0, 16'd5);
      push_cmd(4'd2, 16'd3);
      repeat (c_SETTLE + 2) @(posedge clk);
      repeat (10) @(posedge clk);
      #1;
      check("bp_valid", {31'd0, res_valid}, 32'd1);
      check("bp_in1", {16'd0, alu_input1}, 32'd5);
      res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_pop_in1", {16'd0, alu_input1}, 32'd3);
      check("bp_pop_op", {28'd0, alu_op_code}, 32'd2);
      check("bp_pop_valid", {31'd0, res_valid}, 32'd0);
      wait_idle(50);

      // ---- random traffic
      rdone = 1'b0;
      fork
         begin
            for (int i = 0; i < 60; i++) begin
               logic [15:0] v;
               v = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
               push_cmd(ops[$urandom_range(0, 6)], v);
               repeat ($urandom_range(0, 4)) @(posedge clk);
               #1;
            end
            rdone = 1'b1;
         end
         begin
            while (!rdone) begin
               @(posedge clk);
               #1;
               res_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      res_ready = 1'b1;
      wait_idle(500);
      check("q_drained", cmd_q.size(), 32'd0);

      // ---- reset mid-SETTLE with commands queued
      push_cmd(4'd0, 16'd9);
      wait_idle(50);
      push_cmd(4'd0, 16'd1);
      push_cmd(4'd0, 16'd2);
      push_cmd(4'd0, 16'd3);
      rst = 1'b1;
      #1;
      check("mrst_valid", {31'd0, res_valid}, 32'd0);
      check("mrst_acc", acc, 32'd0);
      check("mrst_ready", {31'd0, cmd_ready}, 32'd1);
      check("mrst_busy", {31'd0, busy}, 32'd0);
      check("mrst_sticky", {31'd0, err_sticky}, 32'd0);
      cmd_q.delete();
      m_acc    = '0;
      m_sticky = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("post_rst_valid", {31'd0, res_valid}, 32'd0);
      end
      check("post_rst_busy", {31'd0, busy}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Command initiator for the 16-bit calculator datapath (op_code / input1 / accumulator-fed input2 → 32-bit output1 plus err_code).
- Queues (op, operand) commands in a small FIFO and drives each command onto the datapath.
- Waits a fixed settle time, then captures the result and error. Error-free results are written into the 32-bit accumulator, whose low half feeds back as input2.
- Returns each result on a valid/ready response port.

Parameters:
DEPTH, 4, command FIFO entries; power of 2, ≥2
SETTLE, 2, cycles the datapath inputs are held before output1/err_code are sampled; ≥1
CLR_OP, 13, op code whose successful completion also clears err_sticky

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept; equals !full
cmd_op  in  4  op code
cmd_operand  in  16  operand, drives input1
alu_input1  out  16  datapath operand A
alu_input2  out  16  datapath operand B = acc[15:0]
alu_op_code  out  4  datapath op select
alu_output1  in  32  datapath result
alu_err_code  in  2  datapath error; bit0 overflow, bit1 divide/mod by zero
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res_data  out  32  captured alu_output1
res_err  out  2  captured alu_err_code
acc  out  32  accumulator
err_sticky  out  1  set by any nonzero captured err
busy  out  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset (async, any time including mid-operation):
  - FIFO emptied; state IDLE.
  - acc, res_data, alu_input1, alu_op_code = 0; res_err = 0; res_valid = 0; err_sticky = 0.
  - Any in-flight result is discarded.
- FIFO:
  - Push on cmd_valid && cmd_ready.
  - cmd_ready depends only on full, so there is no push when full even if a pop occurs the same cycle.
  - A pushed entry is poppable no earlier than the next edge.
  - Pointers wrap mod DEPTH; occupancy counter runs 0..DEPTH.
- States: IDLE, SETTLE, RESP.
- IDLE → SETTLE, when the FIFO is non-empty:
  - Pop the head; load alu_input1 = operand and alu_op_code = op; settle counter = 0.
- SETTLE:
  - Counter increments each edge.
  - On the edge where the counter reaches SETTLE (SETTLE edges after the pop), capture res_data = alu_output1 and res_err = alu_err_code, set res_valid, go to RESP.
  - Accumulator rule at capture:
    - If alu_err_code == 0: acc = alu_output1.
    - Otherwise: acc unchanged and err_sticky = 1.
    - If op == CLR_OP and err == 0: err_sticky = 0.
- RESP:
  - Hold res_* stable while res_valid && !res_ready; no pop in this state.
  - On the handshake edge, clear res_valid. Then:
    - FIFO non-empty → pop directly into SETTLE (same actions as IDLE pop).
    - Otherwise → IDLE.
- Drive signals:
  - alu_input1 and alu_op_code hold their last command value in IDLE and RESP.
  - alu_input2 is combinational from acc[15:0].
- Timing:
  - Push at edge T, FIFO empty, IDLE → pop at T+1, capture at T+1+SETTLE.
  - Back-to-back throughput: one command per SETTLE+1 cycles when res_ready is held high.
- Arithmetic: no arithmetic of its own; acc is a full 32-bit copy of output1, and only the low 16 bits are fed back.

Test Plan:
- Add: SETTLE=2, acc=0, push op 0 operand 11 at T; model output = input1+input2 → alu_input1=11 and alu_input2=0 from T+1; res_valid rises after T+3 with res_data=11, res_err=00, acc=11.
- Subtract chained: acc=11, push op 1 operand 15 → alu_input2=11; res_data=4, acc=4. Then op 2 operand 3 → res_data=12.
- Divide by zero: acc=0, op 3 operand 11, model err=2'b10 → res_err=10, acc stays 0, err_sticky=1. Then op 13, model output 0, err 00 → acc=0, err_sticky=0.
- FIFO full: res_ready=0, cmd_valid held with 6 distinct commands on consecutive cycles → first popped, next 4 fill FIFO, 6th stalled with cmd_ready=0. Release res_ready → all 6 results in push order, res_data stable while stalled.
- Backpressure: res_ready low for 10 cycles during RESP → res_data/res_err/acc unchanged, no pop. Raise → handshake, next command popped same edge.
- Reset mid-SETTLE: assert rst one cycle after a pop with 2 more queued → immediate res_valid=0, acc=0, cmd_ready=1, busy=0, and no result emerges after rst is released.
